// File: rtl/common_param.sv
// Shared opcode constants and write-back state encoding for the MIPS datapath.
package common_param;

   localparam logic [5:0] R_FORM = 6'h00;
   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_SW  = 6'h2B;
   localparam logic [5:0] OP_BEQ = 6'h04;
   localparam logic [5:0] OP_BNE = 6'h05;
   localparam logic [5:0] OP_J   = 6'h02;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] REQ    = 2'd1;
   localparam logic [1:0] WAIT   = 2'd2;
   localparam logic [1:0] COMMIT = 2'd3;

endpackage

// File: rtl/wb_dest_decode.sv
// Destination-register decode: whether an instruction writes the register file,
// and which register (rd for R-form, rt otherwise).
module wb_dest_decode
   import common_param::*;
#(
   parameter int ADDR_W = 5
) (
   input  logic [31:0]       Ins,
   output logic              writes,
   output logic [ADDR_W-1:0] dest
);

   logic ins_unused_s;
   assign ins_unused_s = ^{Ins[25:21], Ins[10:0]};

   // Opcode lookup for destination field and write qualification
   always_comb begin
      writes = 1'b1;
      dest   = ADDR_W'(Ins[20:16]);
      case (Ins[31:26])
         R_FORM:                      dest   = ADDR_W'(Ins[15:11]);
         OP_SW, OP_BEQ, OP_BNE, OP_J: writes = 1'b0;
         default:                     writes = 1'b1;
      endcase
   end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: commits ALU results or loaded words to the register file.
// Optional macro WB_SCOREBOARD_EN adds the Busy_mask read-after-write scoreboard.
module wb_stage
   import common_param::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              In_valid,
   output logic              In_ready,
   input  logic [31:0]       Ins,
   input  logic [DATA_W-1:0] Alu_res,
   output logic              Mem_req,
   output logic [DATA_W-1:0] Mem_addr,
   input  logic              Mem_gnt,
   input  logic              Mem_rvalid,
   input  logic [DATA_W-1:0] Mem_rdata,
   output logic              Wen,
   output logic [ADDR_W-1:0] Waddr,
   output logic [DATA_W-1:0] Wdata
`ifdef WB_SCOREBOARD_EN
   ,
   output logic [31:0]       Busy_mask
`endif
);

   logic [1:0]        state_r, state_n;
   logic              in_ready_r, in_ready_n;
   logic              mem_req_r, mem_req_n;
   logic [DATA_W-1:0] mem_addr_r, mem_addr_n;
   logic              wen_r, wen_n;
   logic [ADDR_W-1:0] waddr_r, waddr_n;
   logic [DATA_W-1:0] wdata_r, wdata_n;
   logic [ADDR_W-1:0] dest_r, dest_n;
   logic              writes_r, writes_n;

   logic              writes_s;
   logic [ADDR_W-1:0] dest_s;
   logic              accept_s;
   logic              is_lw_s;

   wb_dest_decode #(.ADDR_W(ADDR_W)) u_dec (
      .Ins    (Ins),
      .writes (writes_s),
      .dest   (dest_s)
   );

   assign accept_s = In_valid && in_ready_r;
   assign is_lw_s  = (Ins[31:26] == OP_LW);

   // Next-state and registered-output computation
   always_comb begin
      state_n    = state_r;
      in_ready_n = in_ready_r;
      mem_req_n  = mem_req_r;
      mem_addr_n = mem_addr_r;
      wen_n      = 1'b0;
      waddr_n    = waddr_r;
      wdata_n    = wdata_r;
      dest_n     = dest_r;
      writes_n   = writes_r;
      case (state_r)
         IDLE, COMMIT: begin
            if (accept_s) begin
               if (is_lw_s) begin
                  state_n    = REQ;
                  in_ready_n = 1'b0;
                  mem_req_n  = 1'b1;
                  mem_addr_n = Alu_res;
                  dest_n     = dest_s;
                  writes_n   = writes_s;
               end else begin
                  state_n    = COMMIT;
                  in_ready_n = 1'b1;
                  wen_n      = writes_s && (dest_s != {ADDR_W{1'b0}});
                  waddr_n    = dest_s;
                  wdata_n    = Alu_res;
               end
            end else begin
               state_n    = IDLE;
               in_ready_n = 1'b1;
            end
         end
         REQ: begin
            if (Mem_gnt) begin
               mem_req_n = 1'b0;
               if (Mem_rvalid) begin
                  state_n    = COMMIT;
                  in_ready_n = 1'b1;
                  wen_n      = writes_r && (dest_r != {ADDR_W{1'b0}});
                  waddr_n    = dest_r;
                  wdata_n    = Mem_rdata;
               end else begin
                  state_n = WAIT;
               end
            end else begin
               state_n = REQ;
            end
         end
         WAIT: begin
            if (Mem_rvalid) begin
               state_n    = COMMIT;
               in_ready_n = 1'b1;
               wen_n      = writes_r && (dest_r != {ADDR_W{1'b0}});
               waddr_n    = dest_r;
               wdata_n    = Mem_rdata;
            end else begin
               state_n = WAIT;
            end
         end
         default: begin
            state_n    = IDLE;
            in_ready_n = 1'b1;
            mem_req_n  = 1'b0;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_r    <= IDLE;
         in_ready_r <= 1'b0;
         mem_req_r  <= 1'b0;
         mem_addr_r <= {DATA_W{1'b0}};
         wen_r      <= 1'b0;
         waddr_r    <= {ADDR_W{1'b0}};
         wdata_r    <= {DATA_W{1'b0}};
         dest_r     <= {ADDR_W{1'b0}};
         writes_r   <= 1'b0;
      end else begin
         state_r    <= state_n;
         in_ready_r <= in_ready_n;
         mem_req_r  <= mem_req_n;
         mem_addr_r <= mem_addr_n;
         wen_r      <= wen_n;
         waddr_r    <= waddr_n;
         wdata_r    <= wdata_n;
         dest_r     <= dest_n;
         writes_r   <= writes_n;
      end
   end

   assign In_ready = in_ready_r;
   assign Mem_req  = mem_req_r;
   assign Mem_addr = mem_addr_r;
   assign Wen      = wen_r;
   assign Waddr    = waddr_r;
   assign Wdata    = wdata_r;

`ifdef WB_SCOREBOARD_EN
   logic [31:0] busy_r, busy_n;

   // Clear on the committing write, then set for a newly accepted writer
   always_comb begin
      busy_n = busy_r;
      if (wen_r) begin
         busy_n[waddr_r] = 1'b0;
      end else begin
         busy_n = busy_r;
      end
      if (accept_s && writes_s && (dest_s != {ADDR_W{1'b0}})) begin
         busy_n[dest_s] = 1'b1;
      end else begin
         busy_n[0] = 1'b0;
      end
   end

   // Scoreboard register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         busy_r <= 32'd0;
      end else begin
         busy_r <= busy_n;
      end
   end

   assign Busy_mask = busy_r;
`endif

endmodule
